// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C constants, FSM encodings and window helper
`timescale 1ns/1ps
package i2c_pkg;

   localparam logic [6:0]  DEF_DEV_ADDR = 7'h3B;
   localparam logic [15:0] DEF_SUB_BASE = 16'h4000;

   localparam logic ACK_BIT  = 1'b0;
   localparam logic NACK_BIT = 1'b1;

   localparam logic [3:0] ST_IDLE      = 4'd0;
   localparam logic [3:0] ST_ADDR      = 4'd1;
   localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
   localparam logic [3:0] ST_SUBH      = 4'd3;
   localparam logic [3:0] ST_SUBL      = 4'd4;
   localparam logic [3:0] ST_WDATA     = 4'd5;
   localparam logic [3:0] ST_RDATA     = 4'd6;
   localparam logic [3:0] ST_RDATA_ACK = 4'd7;
   localparam logic [3:0] ST_IGNORE    = 4'd8;

   // Sub-phase of a received byte: shifting bits, waiting for the SCL fall that
   // opens the ACK slot, then holding the ACK slot until the next SCL fall.
   localparam logic [1:0] PH_BITS     = 2'd0;
   localparam logic [1:0] PH_ACK_WAIT = 2'd1;
   localparam logic [1:0] PH_ACK      = 2'd2;

   // True when ptr lies in [base, base + 2**depth_log2 - 1], modulo 2**16.
   function automatic logic in_window(input logic [15:0] ptr, input logic [15:0] base,
                                      input int depth_log2);
      logic [15:0] off;
      off = ptr - base;
      return (off >> depth_log2) == 16'd0;
   endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// rtl/i2c_bus_sync.sv - SCL/SDA synchronizer with edge and START/STOP detection
`timescale 1ns/1ps
module i2c_bus_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic scl_in,
   input  logic sda_in,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_s
);

   // bit 0: metastability stage, bit 1: synchronized, bit 2: one-cycle history
   logic [2:0] scl_q;
   logic [2:0] sda_q;

   // Shift both lines through sync + history; reset to the idle-high bus level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_q <= 3'b111;
         sda_q <= 3'b111;
      end else begin
         scl_q <= {scl_q[1:0], scl_in};
         sda_q <= {sda_q[1:0], sda_in};
      end
   end

   assign scl_rise  =  scl_q[1] & ~scl_q[2];
   assign scl_fall  = ~scl_q[1] &  scl_q[2];
   assign start_det =  scl_q[1] &  scl_q[2] &  sda_q[2] & ~sda_q[1];
   assign stop_det  =  scl_q[1] &  scl_q[2] & ~sda_q[2] &  sda_q[1];
   assign sda_s     =  sda_q[1];

endmodule

// File: rtl/i2c_codec_responder.sv
// rtl/i2c_codec_responder.sv - I2C target exposing a byte-wide register window
`timescale 1ns/1ps
module i2c_codec_responder
   import i2c_pkg::*;
#(
   parameter logic [6:0]  DEV_ADDR   = DEF_DEV_ADDR,
   parameter logic [15:0] SUB_BASE   = DEF_SUB_BASE,
   parameter int          DEPTH_LOG2 = 6
) (
   input  logic                  audio_clk,
   input  logic                  reset,
   input  logic                  scl_in,
   input  logic                  sda_in,
   output logic                  sda_oe,
   input  logic [DEPTH_LOG2-1:0] rd_addr,
   output logic [7:0]            rd_data,
   output logic                  wr_strobe,
   output logic [DEPTH_LOG2-1:0] wr_index,
   output logic [7:0]            wr_byte,
   output logic                  busy,
   output logic                  error
);

   localparam int DEPTH = 2**DEPTH_LOG2;

   logic scl_rise, scl_fall, start_det, stop_det, sda_s;

   i2c_bus_sync u_sync (
      .clk       (audio_clk),
      .rst_n     (reset),
      .scl_in    (scl_in),
      .sda_in    (sda_in),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det),
      .sda_s     (sda_s)
   );

   logic [3:0]  state_q;
   logic [1:0]  ph_q;
   logic [3:0]  bit_cnt_q;
   logic [6:0]  shift_q;     // bit 7 of a byte is never stored: it is consumed immediately
   logic [15:0] ptr_q;
   logic        ack_pend_q;
   logic        sda_oe_q;
   logic        busy_q;
   logic [7:0]  mem_q [DEPTH];

   logic [15:0]           ptr_off;
   logic [DEPTH_LOG2-1:0] ptr_idx;
   logic                  in_win;
   logic [7:0]            rx_byte;
   logic [7:0]            rd_val;
   logic                  rx_state;
   logic                  byte_done;
   logic                  rd_load;
   logic [3:0]            rx_next;

   assign ptr_off = ptr_q - SUB_BASE;
   assign ptr_idx = ptr_off[DEPTH_LOG2-1:0];
   assign in_win  = in_window(ptr_q, SUB_BASE, DEPTH_LOG2);
   assign rx_byte = {shift_q, sda_s};
   assign rd_val  = in_win ? mem_q[ptr_idx] : 8'hFF;

   assign rx_state  = (state_q == ST_ADDR) || (state_q == ST_SUBH) ||
                      (state_q == ST_SUBL) || (state_q == ST_WDATA);
   assign byte_done = rx_state && scl_rise && (ph_q == PH_BITS) && (bit_cnt_q == 4'd7);
   // Shift register is (re)loaded at the SCL fall that starts a read byte
   assign rd_load   = scl_fall &&
                      (((state_q == ST_ADDR_ACK) && (ph_q == PH_ACK) && shift_q[0]) ||
                       ((state_q == ST_RDATA_ACK) && (ph_q == PH_ACK_WAIT)));

   assign wr_strobe = byte_done && (state_q == ST_WDATA) && in_win;
   assign wr_index  = ptr_idx;
   assign wr_byte   = rx_byte;
   assign error     = (byte_done && (state_q == ST_WDATA) && !in_win) || (rd_load && !in_win);
   assign sda_oe    = sda_oe_q;
   assign busy      = busy_q;
   assign rd_data   = mem_q[rd_addr];

   // Receive state that follows the end of an ACK slot on the write path
   always_comb begin
      rx_next = state_q;
      case (state_q)
         ST_ADDR_ACK: rx_next = ST_SUBH;
         ST_SUBH:     rx_next = ST_SUBL;
         ST_SUBL:     rx_next = ST_WDATA;
         default:     rx_next = state_q;
      endcase
   end

   // Protocol FSM, pointer, SDA driver and register window
   always_ff @(posedge audio_clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         ph_q       <= PH_BITS;
         bit_cnt_q  <= 4'd0;
         shift_q    <= 7'd0;
         ptr_q      <= 16'd0;
         ack_pend_q <= 1'b0;
         sda_oe_q   <= 1'b0;
         busy_q     <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
      end else begin
         if (wr_strobe) mem_q[ptr_idx] <= rx_byte;

         if (stop_det) begin
            state_q   <= ST_IDLE;
            ph_q      <= PH_BITS;
            bit_cnt_q <= 4'd0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
         end else if (start_det) begin
            state_q   <= ST_ADDR;
            ph_q      <= PH_BITS;
            bit_cnt_q <= 4'd0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b1;
         end else if (rd_load) begin
            shift_q   <= rd_val[6:0];
            sda_oe_q  <= ~rd_val[7];
            state_q   <= ST_RDATA;
            ph_q      <= PH_BITS;
            bit_cnt_q <= 4'd0;
         end else begin
            case (state_q)
               ST_ADDR, ST_ADDR_ACK, ST_SUBH, ST_SUBL, ST_WDATA: begin
                  if (ph_q == PH_BITS) begin
                     if (scl_rise) begin
                        shift_q   <= rx_byte[6:0];
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                     end
                     if (byte_done) begin
                        ph_q       <= PH_ACK_WAIT;
                        ack_pend_q <= 1'b1;
                        case (state_q)
                           ST_ADDR: begin
                              if (rx_byte[7:1] == DEV_ADDR) begin
                                 state_q <= ST_ADDR_ACK;
                              end else begin
                                 state_q <= ST_IGNORE;
                                 ph_q    <= PH_BITS;
                              end
                           end
                           ST_SUBH: ptr_q[15:8] <= rx_byte;
                           ST_SUBL: ptr_q[7:0]  <= rx_byte;
                           default: begin
                              ack_pend_q <= in_win;
                              ptr_q      <= ptr_q + 16'd1;
                           end
                        endcase
                     end
                  end else if (scl_fall) begin
                     if (ph_q == PH_ACK_WAIT) begin
                        sda_oe_q <= ack_pend_q;
                        ph_q     <= PH_ACK;
                     end else begin
                        sda_oe_q  <= 1'b0;
                        ph_q      <= PH_BITS;
                        bit_cnt_q <= 4'd0;
                        state_q   <= rx_next;
                     end
                  end
               end
               ST_RDATA: begin
                  if (scl_rise) begin
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                  end else if (scl_fall) begin
                     if (bit_cnt_q == 4'd8) begin
                        sda_oe_q <= 1'b0;
                        state_q  <= ST_RDATA_ACK;
                        ph_q     <= PH_BITS;
                     end else begin
                        sda_oe_q <= ~shift_q[6];
                        shift_q  <= {shift_q[5:0], 1'b0};
                     end
                  end
               end
               ST_RDATA_ACK: begin
                  if ((ph_q == PH_BITS) && scl_rise) begin
                     if (sda_s == NACK_BIT) begin
                        state_q <= ST_IGNORE;
                     end else begin
                        ptr_q <= ptr_q + 16'd1;
                        ph_q  <= PH_ACK_WAIT;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_codec_responder.sv
// tb/tb_i2c_codec_responder.sv - directed self-checking bench for i2c_codec_responder
`timescale 1ns/1ps
module tb_i2c_codec_responder;

   localparam time T_HALF = 5ns;
   localparam time Q      = 80ns;

   logic       audio_clk = 1'b0;
   logic       reset;
   logic       scl_in;
   logic       sda_m;
   logic       sda_in;
   logic       sda_oe;
   logic [5:0] rd_addr;
   logic [7:0] rd_data;
   logic       wr_strobe;
   logic [5:0] wr_index;
   logic [7:0] wr_byte;
   logic       busy;
   logic       error;

   int checks   = 0;
   int failures = 0;
   int wr_cnt   = 0;
   int err_cnt  = 0;
   logic [5:0] last_idx;
   logic [7:0] last_byte;
   logic       oe_seen;

   assign sda_in = sda_m & ~sda_oe;

   always #T_HALF audio_clk = ~audio_clk;

   i2c_codec_responder dut (
      .audio_clk (audio_clk),
      .reset     (reset),
      .scl_in    (scl_in),
      .sda_in    (sda_in),
      .sda_oe    (sda_oe),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .wr_strobe (wr_strobe),
      .wr_index  (wr_index),
      .wr_byte   (wr_byte),
      .busy      (busy),
      .error     (error)
   );

   always @(negedge audio_clk) begin
      if (wr_strobe) begin
         wr_cnt++;
         last_idx  = wr_index;
         last_byte = wr_byte;
      end
      if (error) err_cnt++;
      if (sda_oe) oe_seen = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic rd_chk(input string tag, input logic [5:0] a, input logic [7:0] e);
      rd_addr = a;
      #1;
      check(tag, {24'd0, rd_data}, {24'd0, e});
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; scl_in = 1'b1; #Q;
      sda_m = 1'b0; #Q;
      scl_in = 1'b0; #Q;
   endtask

   task automatic i2c_rstart();
      sda_m = 1'b1; #Q;
      scl_in = 1'b1; #Q;
      sda_m = 1'b0; #Q;
      scl_in = 1'b0; #Q;
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; #Q;
      scl_in = 1'b1; #Q;
      sda_m = 1'b1; #Q;
   endtask

   task automatic send_bits(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         sda_m = b[i]; #Q;
         scl_in = 1'b1; #Q; #Q;
         scl_in = 1'b0; #Q;
      end
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      send_bits(b);
      sda_m = 1'b1; #Q;
      scl_in = 1'b1; #Q;
      ack = sda_in; #Q;
      scl_in = 1'b0; #Q;
   endtask

   task automatic read_byte(input logic m_ack, output logic [7:0] b);
      sda_m = 1'b1;
      b = 8'h00;
      for (int i = 0; i < 8; i++) begin
         #Q;
         scl_in = 1'b1; #Q;
         b = {b[6:0], sda_in}; #Q;
         scl_in = 1'b0; #Q;
      end
      sda_m = m_ack; #Q;
      scl_in = 1'b1; #Q; #Q;
      scl_in = 1'b0; #Q;
      sda_m = 1'b1;
   endtask

   initial begin
      logic       ack;
      logic [7:0] rb;
      int         base_wr;
      int         base_err;

      reset = 1'b0; scl_in = 1'b1; sda_m = 1'b1; rd_addr = 6'd0; oe_seen = 1'b0;
      repeat (5) @(posedge audio_clk);
      #1;
      check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
      rd_chk("rst_reg3f", 6'h3F, 8'h00);
      @(negedge audio_clk); reset = 1'b1;
      repeat (5) @(posedge audio_clk);

      // single write to 0x4000
      base_wr = wr_cnt;
      i2c_start();
      check("t1_busy", {31'd0, busy}, 32'd1);
      write_byte(8'h76, ack); check("t1_ack_dev", {31'd0, ack}, 32'd0);
      write_byte(8'h40, ack); check("t1_ack_subh", {31'd0, ack}, 32'd0);
      write_byte(8'h00, ack); check("t1_ack_subl", {31'd0, ack}, 32'd0);
      write_byte(8'hA5, ack); check("t1_ack_data", {31'd0, ack}, 32'd0);
      i2c_stop();
      check("t1_wr_cnt", wr_cnt - base_wr, 32'd1);
      check("t1_wr_index", {26'd0, last_idx}, 32'h00);
      check("t1_wr_byte", {24'd0, last_byte}, 32'hA5);
      rd_chk("t1_reg00", 6'h00, 8'hA5);
      check("t1_busy_end", {31'd0, busy}, 32'd0);

      // burst write starting at 0x4010
      base_wr = wr_cnt;
      i2c_start();
      write_byte(8'h76, ack);
      write_byte(8'h40, ack);
      write_byte(8'h10, ack);
      write_byte(8'h11, ack);
      write_byte(8'h22, ack);
      write_byte(8'h33, ack); check("t2_ack_last", {31'd0, ack}, 32'd0);
      i2c_stop();
      check("t2_wr_cnt", wr_cnt - base_wr, 32'd3);
      rd_chk("t2_reg10", 6'h10, 8'h11);
      rd_chk("t2_reg11", 6'h11, 8'h22);
      rd_chk("t2_reg12", 6'h12, 8'h33);

      // foreign address: never acknowledged, nothing written
      base_wr = wr_cnt;
      oe_seen = 1'b0;
      i2c_start();
      write_byte(8'h74, ack); check("t3_nack_addr", {31'd0, ack}, 32'd1);
      write_byte(8'h55, ack); check("t3_nack_data", {31'd0, ack}, 32'd1);
      check("t3_busy_ignore", {31'd0, busy}, 32'd1);
      i2c_stop();
      check("t3_oe_seen", {31'd0, oe_seen}, 32'd0);
      check("t3_wr_cnt", wr_cnt - base_wr, 32'd0);
      check("t3_busy_end", {31'd0, busy}, 32'd0);

      // set pointer 0x4010, repeated START, read two bytes
      base_err = err_cnt;
      i2c_start();
      write_byte(8'h76, ack);
      write_byte(8'h40, ack);
      write_byte(8'h10, ack);
      i2c_rstart();
      write_byte(8'h77, ack); check("t4_ack_rd_addr", {31'd0, ack}, 32'd0);
      read_byte(1'b0, rb); check("t4_rd0", {24'd0, rb}, 32'h11);
      read_byte(1'b1, rb); check("t4_rd1", {24'd0, rb}, 32'h22);
      #Q;
      check("t4_sda_released", {31'd0, sda_oe}, 32'd0);
      i2c_stop();
      check("t4_busy_end", {31'd0, busy}, 32'd0);
      check("t4_err_cnt", err_cnt - base_err, 32'd0);

      // out-of-window write at 0x4100
      base_wr = wr_cnt; base_err = err_cnt;
      i2c_start();
      write_byte(8'h76, ack);
      write_byte(8'h41, ack); check("t5_ack_subh", {31'd0, ack}, 32'd0);
      write_byte(8'h00, ack); check("t5_ack_subl", {31'd0, ack}, 32'd0);
      write_byte(8'h5A, ack); check("t5_nack_data", {31'd0, ack}, 32'd1);
      i2c_stop();
      check("t5_err_cnt", err_cnt - base_err, 32'd1);
      check("t5_wr_cnt", wr_cnt - base_wr, 32'd0);
      rd_chk("t5_reg00", 6'h00, 8'hA5);

      // asynchronous reset while driving a data ACK
      i2c_start();
      write_byte(8'h76, ack);
      write_byte(8'h40, ack);
      write_byte(8'h20, ack);
      send_bits(8'h99);
      sda_m = 1'b1;
      check("t6_ack_drv", {31'd0, sda_oe}, 32'd1);
      @(negedge audio_clk); #2;
      reset = 1'b0;
      #1;
      check("t6_async_oe", {31'd0, sda_oe}, 32'd0);
      check("t6_async_busy", {31'd0, busy}, 32'd0);
      rd_chk("t6_reg00_clr", 6'h00, 8'h00);
      rd_chk("t6_reg20_clr", 6'h20, 8'h00);
      scl_in = 1'b1; sda_m = 1'b1;
      repeat (4) @(posedge audio_clk);
      @(negedge audio_clk); reset = 1'b1;
      repeat (4) @(posedge audio_clk);
      base_wr = wr_cnt;
      i2c_start();
      write_byte(8'h76, ack); check("t6_post_ack_dev", {31'd0, ack}, 32'd0);
      write_byte(8'h40, ack);
      write_byte(8'h05, ack);
      write_byte(8'h3C, ack); check("t6_post_ack_data", {31'd0, ack}, 32'd0);
      i2c_stop();
      check("t6_post_wr_cnt", wr_cnt - base_wr, 32'd1);
      check("t6_post_wr_index", {26'd0, last_idx}, 32'h05);
      rd_chk("t6_post_reg05", 6'h05, 8'h3C);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
